// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, start/redirect controls and the
// decode-facing output register.
interface fetch_unit_if #(
  parameter int INSTRUCTION_SIZE      = 16,
  parameter int INSTRUCTION_ADDR_SIZE = 10
);
  logic                             start;
  logic [INSTRUCTION_ADDR_SIZE-1:0] imem_addr;
  logic [INSTRUCTION_SIZE-1:0]      imem_data;
  // Handshake: an output word moves to decode on a rising edge where
  // out_valid && out_ready; out_instr/out_pc stay stable while out_valid && !out_ready.
  logic                             out_valid;
  logic                             out_ready;
  logic [INSTRUCTION_SIZE-1:0]      out_instr;
  logic [INSTRUCTION_ADDR_SIZE-1:0] out_pc;
  logic                             redirect_valid;
  logic [INSTRUCTION_ADDR_SIZE-1:0] redirect_addr;
  logic                             halted;

  modport master (
    input  start, imem_data, out_ready, redirect_valid, redirect_addr,
    output imem_addr, out_valid, out_instr, out_pc, halted
  );

  modport slave (
    output start, imem_data, out_ready, redirect_valid, redirect_addr,
    input  imem_addr, out_valid, out_instr, out_pc, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC onto the instruction memory and
// registers the returned word for decode, with stall, redirect and halt.
module fetch_unit #(
  parameter int         INSTRUCTION_SIZE      = 16,
  parameter int         INSTRUCTION_ADDR_SIZE = 10,
  parameter logic [3:0] HALT_OPCODE           = 4'h1
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [INSTRUCTION_ADDR_SIZE-1:0] pc_q, pc_d;
  logic                             out_valid_q, out_valid_d;
  logic [INSTRUCTION_SIZE-1:0]      out_instr_q, out_instr_d;
  logic [INSTRUCTION_ADDR_SIZE-1:0] out_pc_q, out_pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        // Redirect takes priority over any capture or stall this cycle.
        if (bus.redirect_valid) begin
          pc_d        = bus.redirect_addr;
          out_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
          out_instr_d = bus.imem_data;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + INSTRUCTION_ADDR_SIZE'(1);
          if (bus.imem_data[INSTRUCTION_SIZE-1 -: 4] == HALT_OPCODE) begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        if (bus.redirect_valid) begin
          state_d     = S_RUN;
          pc_d        = bus.redirect_addr;
          out_valid_d = 1'b0;
        end else if (bus.start) begin
          state_d     = S_RUN;
          pc_d        = '0;
          out_valid_d = 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  // Halt is reported only once decode has taken the halt word.
  assign bus.halted    = (state_q == S_HALTED) && !out_valid_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program counter and decode. Drives the address of the combinational instruction memory (16-bit words, 1024 entries) and registers the returned word with its PC into a valid/ready output register for decode. Handles branch redirects with flush, stalls from decode, and stops fetching after a halt instruction (top nibble 4'h1).

## Interface
- INSTRUCTION_SIZE, 16, instruction word width
- INSTRUCTION_ADDR_SIZE, 10, PC / instruction address width
- HALT_OPCODE, 4'h1, value of instr[INSTRUCTION_SIZE-1 -: 4] that halts fetch
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  leave IDLE/HALTED and begin fetching at address 0
- imem_addr  output  INSTRUCTION_ADDR_SIZE  instruction memory address, equals PC
- imem_data  input  INSTRUCTION_SIZE  instruction memory read data, combinational from imem_addr
- out_valid  output  1  out_instr/out_pc hold a fetched instruction
- out_ready  input  1  decode accepts the output this cycle
- out_instr  output  INSTRUCTION_SIZE  fetched instruction
- out_pc  output  INSTRUCTION_ADDR_SIZE  address out_instr was fetched from
- redirect_valid  input  1  branch taken; flush and restart at redirect_addr
- redirect_addr  input  INSTRUCTION_ADDR_SIZE  branch target
- halted  output  1  state is HALTED and output register is empty

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE.
- imem_addr = pc, combinational from the PC register.
- Capture condition (RUN only): load = !out_valid || out_ready. On load: out_instr <= imem_data, out_pc <= pc, out_valid <= 1, pc <= pc + 1 (modulo 2^INSTRUCTION_ADDR_SIZE; 1023 wraps to 0).
- RUN, out_valid && !out_ready: stall; pc, out_instr, out_pc, out_valid hold.
- RUN, out_valid && out_ready && no load possible never occurs (load covers it).
- Halt: when a load captures a word whose top nibble == HALT_OPCODE, state <= HALTED in the same edge; no further loads. The halt word stays in the output register until accepted; then out_valid <= 0.
- HALTED: halted = !out_valid. start=1 -> state <= RUN, pc <= 0, out_valid <= 0.
- IDLE: no loads, out_valid = 0. start=1 -> state <= RUN, pc <= 0.
- start in RUN: ignored.
- Redirect (RUN or HALTED): pc <= redirect_addr, out_valid <= 0 (held instruction dropped, whether or not out_ready), state <= RUN. Redirect overrides load, stall and halt capture in the same cycle. Redirect in IDLE: ignored.
- Redirect and start in the same cycle in HALTED: redirect wins (pc <= redirect_addr).
- Arithmetic: PC increment is unsigned, width INSTRUCTION_ADDR_SIZE, carry discarded.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state=IDLE, pc=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
- Reset asserted mid-run: all of the above immediately; in-flight instruction lost; start required again.
- Start sampled at edge E0 -> first valid (mem[0]) at edge E1; out_valid high after E1.
- Steady state with out_ready=1: one instruction per cycle, out_pc increments by 1 each cycle.
- Redirect sampled at E0 -> out_valid=0 for one cycle, mem[redirect_addr] valid after E1 (one bubble).
- Halt word captured at E0 -> halted=1 after the edge where it is accepted (out_valid && out_ready); never asserted while out_valid=1.
- No combinational path from out_ready or redirect_valid to any output; all outputs registered except imem_addr (from pc register).

## Test plan
- Reset/start: rst_n low then high, memory = 8101, 8201, 8440, ..., mem[15]=1000; check all outputs 0; pulse start -> next cycle out_instr=16'h8101, out_pc=0; with out_ready=1 successive out_instr 8201, 8440, 2123.
- Stall: hold out_ready=0 for 3 cycles while out_pc=2 -> out_instr=16'h8440, out_pc=2 stable, imem_addr=3 stable; release -> out_pc=3, out_instr=16'h2123.
- Redirect: at out_pc=10 (16'hb003) assert redirect_valid, redirect_addr=3 with out_ready=0 -> out_valid=0 next cycle, then out_instr=16'h2123, out_pc=3.
- Halt: run to mem[15]=16'h1000 -> out_instr=1000, out_pc=15; hold out_ready=0 2 cycles: halted=0, imem_addr stays 16; accept -> out_valid=0, halted=1; further cycles no change; start -> out_instr=8101, out_pc=0, halted=0.
- Redirect flushes halt: redirect_valid with redirect_addr=4 in the cycle after HLT is captured -> halt dropped, halted never asserts, out_pc=4, out_instr=16'h2201.
- Wrap and async reset: redirect to 1023 -> out_pc sequence 1023, 0, 1; assert rst_n=0 between edges -> outputs zero immediately, state IDLE (no fetch until start).
